inst_ram_pipe: RTL and testbench

//  Parametrised, synchronous instruction memory for the fetch stage of the 64-bit core.

---
 rtl/inst_ram_pipe.sv | 96 +++++++++
 tb/tb_inst_ram_pipe.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/inst_ram_pipe.sv
// Pipelined instruction memory for the fetch stage: byte PC in, instruction word out after
// LAT register stages, with stall/flush control, fault detection and a program-load write port.
module inst_ram_pipe #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 1,
  localparam int OFF   = $clog2(DATA_W / 8),
  localparam int IDX   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              fault,
  input  logic              ld_we,
  input  logic [IDX-1:0]    ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  // Misaligned within the word, or beyond the last implemented word.
  function automatic logic is_fault(input logic [ADDR_W-1:0] a);
    is_fault = (a[OFF-1:0] != '0) || ((a >> (OFF + IDX)) != '0);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_p  [LAT];
  logic [ADDR_W-1:0] addr_p [LAT];
  logic              flt_p  [LAT];
  logic [DATA_W-1:0] data_p [LAT];

  logic           adv;
  logic           take;
  logic           req_flt;
  logic [IDX-1:0] rd_idx;

  // Flush wins over stall, so the redirect PC issued with a flush always enters the pipe.
  assign adv     = !stall || flush;
  assign take    = ce && req && adv;
  assign req_flt = is_fault(addr);
  assign rd_idx  = addr[OFF+IDX-1:OFF];

  always_ff @(posedge clk) begin
    if (rst && ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // ---- stage 0 capture and stage 1..LAT-1 shift: control ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < LAT; s++) begin
        vld_p[s]  <= 1'b0;
        addr_p[s] <= '0;
        flt_p[s]  <= 1'b0;
      end
    end else if (adv) begin
      vld_p[0] <= take;
      if (take) begin
        addr_p[0] <= addr;
        flt_p[0]  <= req_flt;
      end
      for (int s = 1; s < LAT; s++) begin
        vld_p[s]  <= vld_p[s-1] && !flush;
        addr_p[s] <= addr_p[s-1];
        flt_p[s]  <= flt_p[s-1];
      end
    end
  end

  // ---- stage 0 capture and stage 1..LAT-1 shift: data (read-first against the load port) ----
  always_ff @(posedge clk) begin
    if (rst && adv) begin
      if (take) begin
        data_p[0] <= req_flt ? '0 : mem[rd_idx];
      end
      for (int s = 1; s < LAT; s++) begin
        data_p[s] <= data_p[s-1];
      end
    end
  end

  // ---- output stage ----
  assign inst_valid = vld_p[LAT-1];
  assign fault      = vld_p[LAT-1] && flt_p[LAT-1];
  assign inst_addr  = addr_p[LAT-1];
  assign inst       = (vld_p[LAT-1] && !flt_p[LAT-1]) ? data_p[LAT-1] : '0;

endmodule

// File: tb/tb_inst_ram_pipe.sv
// Directed bench for inst_ram_pipe: three instances (LAT=1,2,3) share all inputs.
module tb_inst_ram_pipe;
  localparam logic [63:0] W1 = 64'h1111111111111111;
  localparam logic [63:0] W2 = 64'h2222222222222222;
  localparam logic [63:0] W3 = 64'h3333333333333333;
  localparam logic [63:0] W4 = 64'h4444444444444444;
  localparam logic [63:0] WA = 64'hAAAAAAAAAAAAAAAA;

  logic        clk = 1'b0;
  logic        rst, ce, req, stall, flush, ld_we;
  logic [63:0] addr, ld_data;
  logic [9:0]  ld_addr;

  logic [63:0] i1, i2, i3, a1, a2, a3;
  logic        v1, v2, v3, f1, f2, f3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_ram_pipe #(.LAT(1)) u1 (.clk(clk), .rst(rst), .ce(ce), .req(req), .addr(addr),
    .stall(stall), .flush(flush), .inst(i1), .inst_valid(v1), .inst_addr(a1), .fault(f1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  inst_ram_pipe #(.LAT(2)) u2 (.clk(clk), .rst(rst), .ce(ce), .req(req), .addr(addr),
    .stall(stall), .flush(flush), .inst(i2), .inst_valid(v2), .inst_addr(a2), .fault(f2),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  inst_ram_pipe #(.LAT(3)) u3 (.clk(clk), .rst(rst), .ce(ce), .req(req), .addr(addr),
    .stall(stall), .flush(flush), .inst(i3), .inst_valid(v3), .inst_addr(a3), .fault(f3),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] i,
                         input logic [63:0] a, input logic f, input logic ev,
                         input logic [63:0] ei, input logic [63:0] ea, input logic ef);
    chk({tag, ".valid"}, {63'd0, v}, {63'd0, ev});
    chk({tag, ".inst"}, i, ei);
    if (ev) chk({tag, ".addr"}, a, ea);
    chk({tag, ".fault"}, {63'd0, f}, {63'd0, ef});
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1; req = 1'b0; stall = 1'b0; flush = 1'b0;
    ld_we = 1'b0; addr = '0; ld_data = '0; ld_addr = '0;
    tick(); tick();
    chk_out("reset_u1", v1, i1, a1, f1, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("reset_u1.addr0", a1, 64'd0);
    chk("reset_u3.addr0", a3, 64'd0);
    rst = 1'b1;

    // Program load
    ld_we = 1'b1;
    ld_addr = 10'd0; ld_data = W1; tick();
    ld_addr = 10'd1; ld_data = W2; tick();
    ld_addr = 10'd2; ld_data = W3; tick();
    ld_addr = 10'd3; ld_data = W4; tick();
    ld_we = 1'b0;

    // Test 1: back-to-back, LAT=1
    req = 1'b1;
    addr = 64'h0;  tick(); chk_out("t1_0", v1, i1, a1, f1, 1'b1, W1, 64'h0,  1'b0);
    addr = 64'h8;  tick(); chk_out("t1_1", v1, i1, a1, f1, 1'b1, W2, 64'h8,  1'b0);
    addr = 64'h10; tick(); chk_out("t1_2", v1, i1, a1, f1, 1'b1, W3, 64'h10, 1'b0);
    addr = 64'h18; tick(); chk_out("t1_3", v1, i1, a1, f1, 1'b1, W4, 64'h18, 1'b0);
    req = 1'b0;
    tick(); chk_out("t1_idle", v1, i1, a1, f1, 1'b0, 64'd0, 64'd0, 1'b0);
    tick(); tick(); tick();

    // Test 2: LAT=3 latency and single-cycle valid
    req = 1'b1; addr = 64'h8;
    tick(); chk("t2_e0.valid", {63'd0, v3}, 64'd0);
    req = 1'b0;
    tick(); chk("t2_e1.valid", {63'd0, v3}, 64'd0);
    tick(); chk_out("t2_e2", v3, i3, a3, f3, 1'b1, W2, 64'h8, 1'b0);
    tick(); chk_out("t2_e3", v3, i3, a3, f3, 1'b0, 64'd0, 64'd0, 1'b0);
    tick(); tick();

    // Test 3: stall with fetches in flight
    req = 1'b1;
    addr = 64'h0;  tick();
    addr = 64'h8;  tick();
    addr = 64'h10; tick();
    chk_out("t3_pre", v3, i3, a3, f3, 1'b1, W1, 64'h0, 1'b0);
    stall = 1'b1; addr = 64'h18;
    tick(); chk_out("t3_st0", v3, i3, a3, f3, 1'b1, W1, 64'h0, 1'b0);
    chk_out("t3_st0_u1", v1, i1, a1, f1, 1'b1, W3, 64'h10, 1'b0);
    tick(); chk_out("t3_st1", v3, i3, a3, f3, 1'b1, W1, 64'h0, 1'b0);
    chk_out("t3_st1_u1", v1, i1, a1, f1, 1'b1, W3, 64'h10, 1'b0);
    stall = 1'b0; req = 1'b0;
    tick(); chk_out("t3_r0", v3, i3, a3, f3, 1'b1, W2, 64'h8,  1'b0);
    tick(); chk_out("t3_r1", v3, i3, a3, f3, 1'b1, W3, 64'h10, 1'b0);
    tick(); chk_out("t3_r2", v3, i3, a3, f3, 1'b0, 64'd0, 64'd0, 1'b0);
    tick(); tick();

    // Test 4: flush + stall + redirect request in one cycle
    req = 1'b1;
    addr = 64'h0; tick();
    addr = 64'h8; tick();
    flush = 1'b1; stall = 1'b1; addr = 64'h18;
    tick(); chk("t4_f0.valid", {63'd0, v3}, 64'd0);
    chk_out("t4_f0_u1", v1, i1, a1, f1, 1'b1, W4, 64'h18, 1'b0);
    flush = 1'b0; stall = 1'b0; req = 1'b0;
    tick(); chk("t4_f1.valid", {63'd0, v3}, 64'd0);
    chk("t4_f1.inst", i3, 64'd0);
    tick(); chk_out("t4_f2", v3, i3, a3, f3, 1'b1, W4, 64'h18, 1'b0);
    tick(); chk("t4_f3.valid", {63'd0, v3}, 64'd0);
    tick(); tick();

    // Test 5: faults and ce=0
    req = 1'b1;
    addr = 64'h4;    tick(); chk_out("t5_mis", v1, i1, a1, f1, 1'b1, 64'd0, 64'h4, 1'b1);
    addr = 64'h2000; tick(); chk_out("t5_oor", v1, i1, a1, f1, 1'b1, 64'd0, 64'h2000, 1'b1);
    addr = 64'h8000_0000_0000_0008; tick();
    chk_out("t5_hi", v1, i1, a1, f1, 1'b1, 64'd0, 64'h8000_0000_0000_0008, 1'b1);
    addr = 64'h8;    tick(); chk_out("t5_ok", v1, i1, a1, f1, 1'b1, W2, 64'h8, 1'b0);
    ce = 1'b0; addr = 64'h10;
    tick(); chk_out("t5_ce0", v1, i1, a1, f1, 1'b0, 64'd0, 64'd0, 1'b0);
    ce = 1'b1; req = 1'b0;
    tick(); tick(); tick();

    // Test 6: reset mid-flight, memory retained, read-first on load collision
    req = 1'b1; addr = 64'h0;
    tick();
    rst = 1'b0; addr = 64'h8; ld_we = 1'b1; ld_addr = 10'd3; ld_data = 64'hDEAD;
    tick(); chk_out("t6_rst_u2", v2, i2, a2, f2, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("t6_rst_u2.addr0", a2, 64'd0);
    chk_out("t6_rst_u1", v1, i1, a1, f1, 1'b0, 64'd0, 64'd0, 1'b0);
    rst = 1'b1; req = 1'b0; ld_we = 1'b0;
    tick(); chk("t6_post.valid", {63'd0, v2}, 64'd0);
    req = 1'b1; addr = 64'h0; ld_we = 1'b1; ld_addr = 10'd0; ld_data = WA;
    tick(); chk_out("t6_rf", v1, i1, a1, f1, 1'b1, W1, 64'h0, 1'b0);
    ld_we = 1'b0;
    tick(); chk_out("t6_new", v1, i1, a1, f1, 1'b1, WA, 64'h0, 1'b0);
    chk_out("t6_u2_old", v2, i2, a2, f2, 1'b1, W1, 64'h0, 1'b0);
    addr = 64'h18;
    tick(); chk_out("t6_keep", v1, i1, a1, f1, 1'b1, W4, 64'h18, 1'b0);
    req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
